// File: rtl/latch_bank_writer.sv
// latch_bank_writer: write-side sequencer for a bank of active-low-transparent
// D latches. Each accepted write drives the shared data bus, waits a setup
// window, opens exactly one word gate for a fixed pulse, closes it, then
// waits a hold window before returning to IDLE. Every output comes straight
// from a flop, so the gate strobes cannot glitch.
module latch_bank_writer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  lat_d,
  output logic [DEPTH-1:0]  lat_gn,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] OPEN  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // One shared down-counter serves all three timed phases, so it must be
  // wide enough for the longest of them.
  localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAXC  = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int CNT_W = $clog2(MAXC + 1);

  // SETUP is loaded with the full count because the accept edge itself
  // launches lat_d: the extra cycle guarantees SETUP_CYC complete cycles
  // of stable data before the gate flop is allowed to fall. OPEN and HOLD
  // exit when the counter reaches zero, so they load one less than their
  // length.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [ADDR_W:0]  DEPTH_X    = (ADDR_W + 1)'(DEPTH);
  localparam logic [DEPTH-1:0] SEL_ONE    = DEPTH'(1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [DEPTH-1:0]  gn_q, gn_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [DEPTH-1:0]  gate_sel;
  logic              addr_oob;
  logic              accept;

  // An out-of-range address shifts the single one off the top of the
  // vector, so the decoded select is all zero and no gate ever opens.
  assign gate_sel = SEL_ONE << addr_q;
  assign addr_oob = ({1'b0, addr_q} >= DEPTH_X);
  assign accept   = wr_valid & ready_q;

  // Next-state logic: phase sequencing, counter reload on every phase
  // entry, and the registered values of every output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    gn_d    = gn_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = wr_addr;
          data_d  = wr_data;
          cnt_d   = SETUP_LOAD;
          state_d = SETUP;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = OPEN;
          cnt_d   = PULSE_LOAD;
          gn_d    = ~gate_sel;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      OPEN: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          gn_d    = '1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = addr_oob;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        gn_d    = '1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset closes every gate at once, even in
  // the middle of a pulse, without waiting for a clock edge.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      gn_q    <= '1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gn_q    <= gn_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wr_ready = ready_q;
  assign lat_d    = data_q;
  assign lat_gn   = gn_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_latch_bank_writer.sv
// tb_latch_bank_writer: directed bench for latch_bank_writer with three
// parameterisations (defaults, DEPTH=6, stretched setup/hold) and a
// behavioural latch bank watching the default instance.
module tb_latch_bank_writer;

  logic CK = 1'b0;
  logic RN = 1'b1;

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 CK = ~CK;

  logic       vA, rdyA, busyA, doneA, errA;
  logic [2:0] addrA;
  logic [7:0] dataA, latdA, gnA;

  logic       vB, rdyB, busyB, doneB, errB;
  logic [2:0] addrB;
  logic [7:0] dataB, latdB;
  logic [5:0] gnB;

  logic       vC, rdyC, busyC, doneC, errC;
  logic [2:0] addrC;
  logic [7:0] dataC, latdC, gnC;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] refMem   [8];
  logic [7:0] latchMem [8];

  logic [7:0] prevD      = 8'h00;
  logic [7:0] prevGn     = 8'hFF;
  int         sinceD     = 1000;
  int         sinceClose = 1000;
  int         lowCnt     = 0;
  int         notifier   = 0;

  latch_bank_writer dutA (
    .CK(CK), .RN(RN), .wr_valid(vA), .wr_ready(rdyA), .wr_addr(addrA),
    .wr_data(dataA), .lat_d(latdA), .lat_gn(gnA), .busy(busyA),
    .done(doneA), .err(errA)
  );

  latch_bank_writer #(.DEPTH(6)) dutB (
    .CK(CK), .RN(RN), .wr_valid(vB), .wr_ready(rdyB), .wr_addr(addrB),
    .wr_data(dataB), .lat_d(latdB), .lat_gn(gnB), .busy(busyB),
    .done(doneB), .err(errB)
  );

  latch_bank_writer #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dutC (
    .CK(CK), .RN(RN), .wr_valid(vC), .wr_ready(rdyC), .wr_addr(addrC),
    .wr_data(dataC), .lat_d(latdC), .lat_gn(gnC), .busy(busyC),
    .done(doneC), .err(errC)
  );

  // Behavioural DLL_X1 bank on dutA plus setup/hold/width/one-hot watchdog;
  // every violation bumps the notifier, which must stay at zero.
  always @(negedge CK) begin
    if (!RN) begin
      prevD      = latdA;
      prevGn     = gnA;
      sinceD     = 1000;
      sinceClose = 1000;
      lowCnt     = 0;
    end else begin
      if (prevGn !== 8'hFF && gnA === 8'hFF) begin
        if (lowCnt < 2) notifier++;
        sinceClose = 0;
      end else if (gnA === 8'hFF && sinceClose < 1000) begin
        sinceClose++;
      end
      if (latdA !== prevD) begin
        sinceD = 0;
        if (gnA !== 8'hFF || sinceClose < 1) notifier++;
      end else if (sinceD < 1000) begin
        sinceD++;
      end
      if (prevGn === 8'hFF && gnA !== 8'hFF) begin
        if (sinceD < 1) notifier++;
        lowCnt = 1;
      end else if (gnA !== 8'hFF) begin
        lowCnt++;
      end
      if ($countones(~gnA) > 1) notifier++;
      for (int i = 0; i < 8; i++) begin
        if (gnA[i] === 1'b0) latchMem[i] = latdA;
      end
      prevD  = latdA;
      prevGn = gnA;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int dut, input logic v, input logic [2:0] a,
                               input logic [7:0] d);
    case (dut)
      0: begin vA = v; addrA = a; dataA = d; end
      1: begin vB = v; addrB = a; dataB = d; end
      default: begin vC = v; addrC = a; dataC = d; end
    endcase
  endtask

  task automatic writeA(input logic [2:0] a, input logic [7:0] d);
    int n;
    n = 0;
    while (rdyA !== 1'b1 && n < 20) begin
      @(negedge CK);
      n++;
    end
    checkOutput("writeA_ready", {31'd0, rdyA}, 32'd1);
    applyStimulus(0, 1'b1, a, d);
    @(posedge CK);
    @(negedge CK);
    applyStimulus(0, 1'b0, a, d);
    refMem[a] = d;
  endtask

  int firstDone, d22Edge, dones, n;

  initial begin
    applyStimulus(0, 1'b0, 3'd0, 8'h00);
    applyStimulus(1, 1'b0, 3'd0, 8'h00);
    applyStimulus(2, 1'b0, 3'd0, 8'h00);

    // Power-on reset, checked before any clock edge
    #1 RN = 1'b0;
    #1;
    checkOutput("por_gn",    {24'd0, gnA},    32'hFF);
    checkOutput("por_latd",  {24'd0, latdA},  32'h00);
    checkOutput("por_ready", {31'd0, rdyA},   32'd1);
    checkOutput("por_busy",  {31'd0, busyA},  32'd0);
    checkOutput("por_done",  {31'd0, doneA},  32'd0);
    checkOutput("por_err",   {31'd0, errA},   32'd0);
    repeat (2) @(negedge CK);
    RN = 1'b1;
    @(negedge CK);

    // Single write addr 5 / A5; edge 0 is the accept edge
    applyStimulus(0, 1'b1, 3'd5, 8'hA5);
    @(posedge CK);
    @(negedge CK);
    applyStimulus(0, 1'b0, 3'd1, 8'h00);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge CK);
      checkOutput($sformatf("single_gn_e%0d", k), {24'd0, gnA},
                  (k == 2 || k == 3) ? 32'hDF : 32'hFF);
      checkOutput($sformatf("single_done_e%0d", k), {31'd0, doneA}, (k == 5) ? 32'd1 : 32'd0);
      checkOutput($sformatf("single_ready_e%0d", k), {31'd0, rdyA}, (k >= 5) ? 32'd1 : 32'd0);
      checkOutput($sformatf("single_busy_e%0d", k), {31'd0, busyA}, (k < 5) ? 32'd1 : 32'd0);
      checkOutput($sformatf("single_latd_e%0d", k), {24'd0, latdA}, 32'hA5);
    end
    refMem[5] = 8'hA5;

    // Back-to-back with wr_valid held high across both writes
    applyStimulus(0, 1'b1, 3'd3, 8'h11);
    @(posedge CK);
    @(negedge CK);
    checkOutput("b2b_latd_e0", {24'd0, latdA}, 32'h11);
    applyStimulus(0, 1'b1, 3'd3, 8'h22);
    firstDone = -1;
    d22Edge   = -1;
    dones     = 0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge CK);
      if (doneA === 1'b1) begin
        dones++;
        if (firstDone < 0) firstDone = k;
      end
      if (latdA === 8'h22 && d22Edge < 0) d22Edge = k;
      if (k == 6) applyStimulus(0, 1'b0, 3'd3, 8'h22);
    end
    checkOutput("b2b_first_done_edge", firstDone, 32'd5);
    checkOutput("b2b_d22_edge", d22Edge, 32'd6);
    checkOutput("b2b_done_count", dones, 32'd2);
    refMem[3] = 8'h22;

    // Latch bank fill then random writes, followed by readback
    for (int i = 0; i < 8; i++) writeA(3'(i), 8'(i * 17 + 3));
    for (int i = 0; i < 16; i++) writeA(3'($urandom_range(7)), 8'($urandom_range(255)));
    n = 0;
    while (rdyA !== 1'b1 && n < 20) begin
      @(negedge CK);
      n++;
    end
    repeat (2) @(negedge CK);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("latch_word%0d", i), {24'd0, latchMem[i]}, {24'd0, refMem[i]});
    checkOutput("latch_timing_notifier", notifier, 32'd0);

    // DEPTH=6 instance: out-of-range address 7
    applyStimulus(1, 1'b1, 3'd7, 8'h3C);
    @(posedge CK);
    @(negedge CK);
    applyStimulus(1, 1'b0, 3'd0, 8'h00);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge CK);
      checkOutput($sformatf("oob_gn_e%0d", k), {26'd0, gnB}, 32'h3F);
      checkOutput($sformatf("oob_done_e%0d", k), {31'd0, doneB}, (k == 5) ? 32'd1 : 32'd0);
      checkOutput($sformatf("oob_err_e%0d", k), {31'd0, errB}, (k == 5) ? 32'd1 : 32'd0);
    end

    // DEPTH=6 instance: top legal word 5
    applyStimulus(1, 1'b1, 3'd5, 8'hC3);
    @(posedge CK);
    @(negedge CK);
    applyStimulus(1, 1'b0, 3'd0, 8'h00);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge CK);
      checkOutput($sformatf("top_gn_e%0d", k), {26'd0, gnB},
                  (k == 2 || k == 3) ? 32'h1F : 32'h3F);
      checkOutput($sformatf("top_done_e%0d", k), {31'd0, doneB}, (k == 5) ? 32'd1 : 32'd0);
      checkOutput($sformatf("top_err_e%0d", k), {31'd0, errB}, 32'd0);
    end

    // Stretched timing instance: setup 3, pulse 1, hold 2
    applyStimulus(2, 1'b1, 3'd1, 8'h5A);
    @(posedge CK);
    @(negedge CK);
    applyStimulus(2, 1'b0, 3'd0, 8'h00);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge CK);
      checkOutput($sformatf("slow_gn_e%0d", k), {24'd0, gnC}, (k == 4) ? 32'hFD : 32'hFF);
      checkOutput($sformatf("slow_done_e%0d", k), {31'd0, doneC}, (k == 7) ? 32'd1 : 32'd0);
      checkOutput($sformatf("slow_ready_e%0d", k), {31'd0, rdyC}, (k >= 7) ? 32'd1 : 32'd0);
    end
    checkOutput("slow_latd", {24'd0, latdC}, 32'h5A);

    // Reset asserted while gate 2 is open, between clock edges
    applyStimulus(0, 1'b1, 3'd2, 8'h77);
    @(posedge CK);
    @(negedge CK);
    applyStimulus(0, 1'b0, 3'd0, 8'h00);
    @(negedge CK);
    @(negedge CK);
    checkOutput("midrst_pre_gn", {24'd0, gnA}, 32'hFB);
    #2 RN = 1'b0;
    #1;
    checkOutput("midrst_gn",    {24'd0, gnA},   32'hFF);
    checkOutput("midrst_latd",  {24'd0, latdA}, 32'h00);
    checkOutput("midrst_ready", {31'd0, rdyA},  32'd1);
    checkOutput("midrst_busy",  {31'd0, busyA}, 32'd0);
    @(negedge CK);
    RN = 1'b1;
    repeat (2) @(negedge CK);
    checkOutput("postrst_gn",    {24'd0, gnA},  32'hFF);
    checkOutput("postrst_ready", {31'd0, rdyA}, 32'd1);
    checkOutput("postrst_done",  {31'd0, doneA}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
